gpr_exec_unit: RTL

- Parametrised successor of the single-cycle GPR ALU core.
- Accepts 32-bit instructions over a valid/ready handshake and executes them against a clocked register file of REG_CNT words, each DATA_W bits wide.
- Maintains registered condition flags and a special high-product register (SGPR).
- Adds din load and dout store instructions and a multi-cycle multiplier.
- Sits between the instruction fetch/sequencer and the I/O pins.

---
 rtl/gpr_exec_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gpr_exec_unit.sv
// gpr_exec_unit: handshaked GPR execution unit with flags, SGPR, din/dout and shift-add multiplier.
// Define FAST_MUL_EN for a single-cycle multiplier instead of the iterative one.
module gpr_exec_unit #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [3:0]        flags,
  output logic              illegal_op
);
  localparam int AW = $clog2(REG_CNT);
  localparam int PW = 2 * DATA_W;
  logic [DATA_W-1:0] gpr_q [REG_CNT];
  logic [DATA_W-1:0] sgpr_q, dout_q;
  logic [3:0]        flags_q, flags_d;
  logic              dout_valid_q, illegal_q, accept, wr_d, ov_d, cy_d;
  logic [4:0]        op;
  logic [AW-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] imm, a, b, res_d, diff;
  logic [DATA_W:0]   sum;
  assign op     = instr[31:27];
  assign rd     = instr[22 +: AW];
  assign rs1    = instr[17 +: AW];
  assign rs2    = instr[11 +: AW];
  assign imm    = DATA_W'(instr[15:0]);
  assign accept = instr_valid && instr_ready;
`ifdef FAST_MUL_EN
  logic [PW-1:0] prod;
  assign prod        = PW'(a) * PW'(b);
  assign instr_ready = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  localparam int CW = $clog2(DATA_W);
  state_t            state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [PW-1:0]     prod_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     rd_q;
  assign instr_ready = state_q == IDLE;
`endif
  always_comb begin
    a     = gpr_q[rs1];
    b     = instr[16] ? imm : gpr_q[rs2];
    sum   = {1'b0, a} + {1'b0, b};
    diff  = a - b;
    res_d = '0;
    wr_d  = 1'b1;
    ov_d  = 1'b0;
    cy_d  = 1'b0;
    case (op)
      5'd0: res_d = sgpr_q;
      5'd1: res_d = instr[16] ? imm : a;
      5'd2: begin
        res_d = sum[DATA_W-1:0];
        cy_d  = sum[DATA_W];
        ov_d  = (a[DATA_W-1] == b[DATA_W-1]) && (res_d[DATA_W-1] != a[DATA_W-1]);
      end
      5'd3: begin
        res_d = diff;
        cy_d  = a < b;
        ov_d  = (a[DATA_W-1] != b[DATA_W-1]) && (res_d[DATA_W-1] != a[DATA_W-1]);
      end
`ifdef FAST_MUL_EN
      5'd4: res_d = prod[DATA_W-1:0];
`else
      5'd4: wr_d = 1'b0;
`endif
      5'd5:  res_d = a | b;
      5'd6:  res_d = a & b;
      5'd7:  res_d = a ^ b;
      5'd8:  res_d = ~(a ^ b);
      5'd9:  res_d = ~(a & b);
      5'd10: res_d = ~(a | b);
      5'd11: res_d = ~(instr[16] ? imm : a);
      5'd12: res_d = din;
      default: wr_d = 1'b0;
    endcase
    flags_d = {res_d[DATA_W-1], res_d == '0, ov_d, cy_d};
`ifdef FAST_MUL_EN
    if (op == 5'd4) flags_d = {prod[PW-1], prod == '0, 2'b00};
`endif
  end
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < REG_CNT; i++) gpr_q[i] <= '0;
      sgpr_q       <= '0;
      dout_q       <= '0;
      flags_q      <= '0;
      dout_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
`ifndef FAST_MUL_EN
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
`endif
    end else begin
      dout_valid_q <= accept && op == 5'd13;
      illegal_q    <= accept && op >= 5'd14;
      if (accept && wr_d) begin
        gpr_q[rd] <= res_d;
        flags_q   <= flags_d;
      end
      if (accept && op == 5'd13) dout_q <= a;
`ifdef FAST_MUL_EN
      if (accept && op == 5'd4) sgpr_q <= prod[PW-1:DATA_W];
`else
      case (state_q)
        IDLE: if (accept && op == 5'd4) begin
          state_q <= MUL;
          a_q     <= a;
          b_q     <= b;
          prod_q  <= '0;
          cnt_q   <= CW'(DATA_W - 1);
          rd_q    <= rd;
        end
        // MSB-first shift-add: one multiplier bit per cycle
        MUL: begin
          prod_q <= {prod_q[PW-2:0], 1'b0} + (b_q[cnt_q] ? PW'(a_q) : PW'(0));
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= WB;
        end
        WB: begin
          gpr_q[rd_q] <= prod_q[DATA_W-1:0];
          sgpr_q      <= prod_q[PW-1:DATA_W];
          flags_q     <= {prod_q[PW-1], prod_q == '0, 2'b00};
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`endif
    end
  end
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;
endmodule
